random_arbiter: RTL and testbench
=================================

Name: random_arbiter

Overview:
- Shares the single 8-bit noise-seeded LFSR generator (Random) between NUM_REQ consumers, e.g. sprite/particle engines in the VGA pipeline.
- Instantiates Random, counts LFSR advances since the last delivery, and hands a byte to one requester only after at least STRIDE fresh shifts. This keeps consumers from receiving shifted copies of each other's values.
- Uses a round-robin req/grant handshake with registered one-cycle grant and data.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- STRIDE, 8: minimum LFSR clocks between deliveries, 1..255.
- CNT_W, 8: width of the stride counter; must hold STRIDE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- noise  in  1  entropy bit, forwarded unchanged to Random
- req  in  NUM_REQ  level request per consumer; held until granted
- grant  out  NUM_REQ  one-hot, one-cycle pulse naming the served requester
- data  out  8  random byte delivered with grant; held until the next grant
- valid  out  1  high for the same cycle as grant
- busy  out  1  high while the stride counter is below STRIDE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - grant=0, valid=0, data=8'd0, busy=1.
  - Stride counter is 0. Round-robin pointer is 0, so requester 0 has highest priority.
  - rst is also driven into Random, which resets with it.
- Random advances every clk after reset. The arbiter never stalls it; it samples the current value only.
- Stride counter:
  - Increments each clk edge and saturates at STRIDE.
  - busy = (counter < STRIDE), combinational from the counter.
- States:
  - ACCUM: counter < STRIDE; no grant is issued.
  - READY: counter == STRIDE, waiting for any request.
  - Transitions: ACCUM -> READY when the counter reaches STRIDE. READY -> ACCUM at the grant edge.
- Grant edge (READY and |req):
  - grant <= one-hot of the first set req bit, searching from ptr upward with wrap-around.
  - data <= current Random output, i.e. the value visible before the edge.
  - valid <= 1; counter <= 0; ptr <= granted index + 1 mod NUM_REQ.
  - On every other edge: grant <= 0, valid <= 0, data holds.
- Latency and throughput:
  - Grant appears one clk after the edge where READY and req are both seen.
  - Minimum spacing between grants is STRIDE+1 clks.
- Requester rules:
  - A requester may drop req before being granted; it is then simply not served. No error and no stale grant.
  - A requester must drop req the cycle after its grant, or it is re-queued.
- Boundary cases:
  - All req bits set: grants rotate 0,1,2,...,NUM_REQ-1,0, each STRIDE+1 clks apart.
  - req=0 in READY: state holds indefinitely; counter stays saturated.
  - rst asserted mid-grant: the grant pulse is cancelled next edge and all state returns to reset values; no partial delivery.
  - STRIDE=1: a grant is possible every 2 clks.

Decomposition:
- Shared package:
  - RANDOM_WIDTH = 8.
  - Arbiter state encoding: ACCUM = 1'b0, READY = 1'b1.
- Instantiates the existing Random module unchanged.
- One natural sub-module: rr_pick, a combinational round-robin selector taking req and ptr and returning a one-hot grant and a found flag. It is reusable by the other VGA bus arbiters.

Test Plan:
- Reset release, STRIDE=4, req=4'b0001 held, noise=1,1,0,1 on edges 1–4 (Random shows 1,2,5,11) -> busy falls after edge 4; at edge 5 grant=4'b0001, valid=1, data=8'd11 for one cycle.
- STRIDE=4, req=4'b1111 held, noise=1 -> grants in order 0001, 0010, 0100, 1000, 0001, spaced exactly 5 clks; valid mirrors grant.
- req=4'b0100 only, granted, then req=4'b0101 -> next grant is 4'b0001 (ptr wrapped past index 2 to index 3 then 0), not 0100.
- req[1] pulsed for 2 cycles while busy=1, then dropped -> no grant is ever issued; data holds its previous value.
- rst asserted on the cycle grant is high -> the following cycle has grant=0, valid=0, data=0, busy=1; the counter restarts and the first grant after release again needs STRIDE+1 clks.
- STRIDE=255, req=1 held, noise=1 -> first data captured; repeat grants for 255 deliveries -> no two consecutive data values are equal; Random's maximal-length period is preserved.

Source files
------------

// File: rtl/random_arbiter_pkg.sv
// Shared types and constants for the random byte arbiter.
// Imported by the arbiter top and its selector.
package random_arbiter_pkg;

    localparam int RANDOM_WIDTH = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        READY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/Random.sv
// Noise-seeded 8-bit LFSR, x^8+x^7+x^6+x^5+x^2+x+1.
// The entropy bit is folded into the feedback on every clock.
module Random (
    input  logic       clk,
    input  logic       rst,
    input  logic       noise,
    output logic [7:0] rnd
);

    localparam logic [7:0] TAPS = 8'b1110_0111;

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd <= '0;
        end else begin
            rnd <= {rnd[6:0], noise ^ (^(rnd & TAPS))};
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: lowest set req at or above
// ptr, else lowest set req overall. Result is one-hot.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          found
);

    logic [N-1:0] hi;
    logic [N-1:0] pick_hi;
    logic [N-1:0] pick_all;

    // x & -x isolates the lowest set bit
    assign hi       = req & ~((N'(1) << ptr) - N'(1));
    assign pick_hi  = hi & (~hi + N'(1));
    assign pick_all = req & (~req + N'(1));
    assign gnt      = (|hi) ? pick_hi : pick_all;
    assign found    = |req;

endmodule

// File: rtl/random_arbiter.sv
// Shares one Random LFSR among NUM_REQ consumers, delivering a byte
// only after STRIDE fresh shifts since the previous delivery.
module random_arbiter
    import random_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int STRIDE  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    noise,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      grant,
    output logic [RANDOM_WIDTH-1:0] data,
    output logic                    valid,
    output logic                    busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    arb_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] ptr_nxt;
    logic [NUM_REQ-1:0] pick;
    logic found;
    logic [RANDOM_WIDTH-1:0] rnd;

    Random u_random (
        .clk   (clk),
        .rst   (rst),
        .noise (noise),
        .rnd   (rnd)
    );

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (pick),
        .found (found)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) gidx = PW'(i);
        end
    end

    assign ptr_nxt = (gidx == LAST) ? '0 : gidx + PW'(1);
    assign busy    = cnt < STRIDE_C;

    // counter saturates in READY because only ACCUM advances it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            cnt   <= '0;
            ptr   <= '0;
            grant <= '0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            grant <= '0;
            valid <= 1'b0;
            unique case (state)
                ACCUM: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt + CNT_W'(1) == STRIDE_C) state <= READY;
                end
                READY: begin
                    if (found) begin
                        grant <= pick;
                        valid <= 1'b1;
                        data  <= rnd;
                        cnt   <= '0;
                        ptr   <= ptr_nxt;
                        state <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_arbiter.sv
// Scoreboard bench for random_arbiter: STRIDE=4 and STRIDE=255
// instances, expectations queued by stimulus, popped by monitors.
module tb_random_arbiter;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, noise_a;
    logic [3:0] req_a, grant_a;
    logic [7:0] data_a;
    logic       valid_a, busy_a;

    logic       rst_b, noise_b;
    logic [3:0] req_b, grant_b;
    logic [7:0] data_b;
    logic       valid_b, busy_b;

    exp_t qa[$];
    exp_t qb[$];
    int total = 0;
    int bad = 0;
    int nb = 0;

    random_arbiter #(.NUM_REQ(4), .STRIDE(4), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .noise (noise_a),
        .req   (req_a),
        .grant (grant_a),
        .data  (data_a),
        .valid (valid_a),
        .busy  (busy_a)
    );

    random_arbiter #(.NUM_REQ(4), .STRIDE(255), .CNT_W(8)) dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .noise (noise_b),
        .req   (req_b),
        .grant (grant_b),
        .data  (data_b),
        .valid (valid_b),
        .busy  (busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // reference LFSR with noise held at 1
    function automatic logic [7:0] step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[6] ^ v[5] ^ v[2] ^ v[1] ^ v[0] ^ 1'b1;
        return {v[6:0], fb};
    endfunction

    function automatic logic [7:0] lf(input int n);
        logic [7:0] v;
        v = 8'd0;
        for (int i = 0; i < n; i++) v = step(v);
        return v;
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (valid_a || grant_a != 4'd0) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected: grant=%b valid=%b cyc=%0d",
                         grant_a, valid_a, cyc);
            end else begin
                e = qa.pop_front();
                chk("a_grant", grant_a, e.g);
                chk("a_valid", valid_a, 1);
                chk("a_data", data_a, e.d);
                chk("a_cycle", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        logic [7:0] prev;
        if (valid_b || grant_b != 4'd0) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected: grant=%b valid=%b cyc=%0d",
                         grant_b, valid_b, cyc);
            end else begin
                e = qb.pop_front();
                chk("b_grant", grant_b, e.g);
                chk("b_valid", valid_b, 1);
                chk("b_data", data_b, e.d);
                chk("b_cycle", cyc, e.at);
                if (nb > 0) begin
                    total++;
                    if (data_b === prev) begin
                        bad++;
                        $display("FAIL b_repeat: got %0d want not %0d",
                                 data_b, prev);
                    end
                end
                prev = data_b;
                nb++;
            end
        end
    end

    initial begin
        int e0, e1, rb;
        logic [7:0] dv;
        rst_a = 1'b1; noise_a = 1'b0; req_a = 4'd0;
        rst_b = 1'b1; noise_b = 1'b1; req_b = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_busy", busy_a, 1);

        // first delivery: noise 1,1,0,1 gives 1,2,5,11
        rst_a = 1'b0; req_a = 4'b0001; noise_a = 1'b1; e0 = cyc;
        qa.push_back('{4'b0001, 8'd11, e0 + 5});
        @(negedge clk);
        @(negedge clk); noise_a = 1'b0;
        @(negedge clk); noise_a = 1'b1;
        chk("t1_busy_e3", busy_a, 1);
        @(negedge clk);
        chk("t1_busy_e4", busy_a, 0);
        @(negedge clk); req_a = 4'd0;

        // all requesters: rotation every STRIDE+1 clks
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; req_a = 4'b1111; e0 = cyc;
        for (int k = 1; k <= 5; k++)
            qa.push_back('{4'(1 << ((k - 1) % 4)), lf(5 * k - 1), e0 + 5 * k});
        repeat (25) @(negedge clk);

        // pointer moves past index 2
        req_a = 4'b0100; e1 = cyc;
        qa.push_back('{4'b0100, lf(e1 + 4 - e0), e1 + 5});
        repeat (5) @(negedge clk);
        req_a = 4'b0101;
        qa.push_back('{4'b0001, lf(e1 + 9 - e0), e1 + 10});
        repeat (5) @(negedge clk);

        // abandoned request while busy
        dv = lf(e1 + 9 - e0);
        req_a = 4'b0010;
        @(negedge clk);
        chk("t4_busy", busy_a, 1);
        @(negedge clk); req_a = 4'd0;
        repeat (10) @(negedge clk);
        chk("t4_hold_data", data_a, dv);
        chk("t4_grant", grant_a, 0);
        chk("t4_ready", busy_a, 0);

        // reset during the grant pulse
        req_a = 4'b1000;
        qa.push_back('{4'b1000, lf(cyc - e0), cyc + 1});
        @(negedge clk);
        chk("t5_pulse", grant_a, 4'b1000);
        rst_a = 1'b1;
        @(negedge clk);
        chk("t5_grant", grant_a, 0);
        chk("t5_valid", valid_a, 0);
        chk("t5_data", data_a, 0);
        chk("t5_busy", busy_a, 1);
        rst_a = 1'b0; e0 = cyc;
        qa.push_back('{4'b1000, lf(4), e0 + 5});
        repeat (5) @(negedge clk);
        req_a = 4'd0;
        repeat (3) @(negedge clk);

        // long stride, 255 deliveries
        rst_b = 1'b0; req_b = 4'b0001; rb = cyc;
        dv = lf(255);
        for (int k = 1; k <= 255; k++) begin
            qb.push_back('{4'b0001, dv, rb + 256 * k});
            for (int i = 0; i < 256; i++) dv = step(dv);
        end
        repeat (255 * 256 + 2) @(negedge clk);
        req_b = 4'd0;
        repeat (4) @(negedge clk);

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        chk("b_count", nb, 255);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
